// File: rtl/sprite_line_selector.sv
// Sprite line selector: scans N_SPR attribute entries from highest to lowest index
// and captures up to K_SLOTS active sprites as {tag, attr} slots.
module sprite_line_selector #(
  parameter int N_SPR   = 32,
  parameter int K_SLOTS = 4,
  parameter int ATTR_W  = 18,
  parameter int IDX_W   = $clog2(N_SPR),
  parameter int TAG_W   = $clog2(N_SPR + 1),
  parameter int SLOT_W  = TAG_W + ATTR_W,
  parameter int CNT_W   = $clog2(K_SLOTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [IDX_W-1:0]           rd_addr,
  input  logic [ATTR_W-1:0]          rd_data,
  output logic [K_SLOTS*SLOT_W-1:0]  slot_data,
  output logic [CNT_W-1:0]           slot_cnt,
  output logic                       overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            r_pend_idx;
  logic                        r_pend;
  logic [K_SLOTS*SLOT_W-1:0]   r_slot_data;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_ovf;

  logic                        w_rd_en;
  logic                        w_eval;
  logic                        w_active;
  logic                        w_full;
  logic                        w_ovf_hit;
  logic                        w_accept;
  logic [TAG_W-1:0]            w_tag;

  // Read data returned this cycle belongs to the index issued last cycle; it only
  // counts while the scan is still live (SCAN or DRAIN), so an in-flight read
  // after early termination is dropped.
  assign w_eval    = r_pend && ((r_state == S_SCAN) || (r_state == S_DRAIN));
  assign w_active  = (rd_data != '0);
  assign w_full    = (r_cnt == CNT_W'(K_SLOTS));
  assign w_ovf_hit = w_eval && w_active && w_full;
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_tag     = TAG_W'(N_SPR) - TAG_W'(r_pend_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SCAN;
      end
      S_SCAN: begin
        busy    = 1'b1;
        w_rd_en = 1'b1;
        if (w_ovf_hit)          w_next = S_DONE;
        else if (r_idx == '0)   w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_pend_idx  <= '0;
      r_pend      <= 1'b0;
      r_slot_data <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_pend     <= w_rd_en;
      r_pend_idx <= r_idx;
      if (w_accept) begin
        r_idx       <= IDX_W'(N_SPR - 1);
        r_slot_data <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else begin
        if (r_state == S_SCAN) r_idx <= r_idx - IDX_W'(1);
        if (w_eval && w_active) begin
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            for (int unsigned k = 0; k < K_SLOTS; k++) begin
              if (r_cnt == CNT_W'(k)) r_slot_data[k*SLOT_W +: SLOT_W] <= {w_tag, rd_data};
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign rd_en     = w_rd_en;
  assign rd_addr   = w_rd_en ? r_idx : '0;
  assign slot_data = r_slot_data;
  assign slot_cnt  = r_cnt;
  assign overflow  = r_ovf;

endmodule

// File: doc/sprite_line_selector.md
SPRITE_LINE_SELECTOR -- requirements
Module: sprite_line_selector

Interface
REQ-001 Parameter N_SPR, default 32: number of sprite entries scanned (≥2).
REQ-002 Parameter K_SLOTS, default 4: output slot count (1..N_SPR).
REQ-003 Parameter ATTR_W, default 18: sprite attribute width; all-zero attribute = inactive sprite.
REQ-004 Derived widths SHALL be: IDX_W=clog2(N_SPR); TAG_W=clog2(N_SPR+1); SLOT_W=TAG_W+ATTR_W; CNT_W=clog2(K_SLOTS+1).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  scan request; sampled only in IDLE.
REQ-008 busy  out  1  high while scanning (SCAN and DRAIN).
REQ-009 done  out  1  one-cycle pulse; results valid.
REQ-010 rd_en  out  1  attribute read strobe.
REQ-011 rd_addr  out  IDX_W  sprite index to read.
REQ-012 rd_data  in  ATTR_W  attribute of rd_addr, valid exactly one cycle after rd_en.
REQ-013 slot_data  out  K_SLOTS*SLOT_W  slot k at bits [(k+1)*SLOT_W-1 : k*SLOT_W], packed {tag, attr}; slot 0 = highest priority.
REQ-014 slot_cnt  out  CNT_W  number of filled slots.
REQ-015 overflow  out  1  more than K_SLOTS active sprites present.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, DRAIN, DONE.
REQ-017 IDLE->SCAN on start=1; in that same edge slot_data, slot_cnt, overflow SHALL clear to 0 and the scan index loads N_SPR-1.
REQ-018 In SCAN, each cycle: rd_en=1, rd_addr=current index, index decrements; after issuing index 0 -> DRAIN.
REQ-019 Priority SHALL descend from index N_SPR-1 (highest) to 0 (lowest).
REQ-020 Each returned rd_data≠0 with slot_cnt<K_SLOTS SHALL be written to slot[slot_cnt] as {tag=N_SPR-index, rd_data}, and slot_cnt increments; tags unique, range 1..N_SPR; tag 0 denotes empty slot.
REQ-021 A returned rd_data≠0 with slot_cnt=K_SLOTS SHALL set overflow=1 and force DONE next cycle (early termination); any read in flight is discarded.
REQ-022 DRAIN SHALL evaluate the final returned read (rd_en=0), then -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, busy=0, rd_en=0; -> IDLE.
REQ-024 Latency without early termination: start accepted at edge 0; SCAN cycles 1..N_SPR; DRAIN cycle N_SPR+1; done high cycle N_SPR+2.
REQ-025 start while busy or in DONE SHALL be ignored (no restart, no queueing).
REQ-026 slot_data, slot_cnt, overflow SHALL hold stable from done until next accepted start.
REQ-027 rd_en SHALL be 0 in IDLE, DRAIN, DONE; rd_addr is don't-care when rd_en=0 but SHALL not produce X.

Reset
REQ-028 rst_n=0 at any time (including mid-scan) SHALL immediately force IDLE, busy=0, done=0, rd_en=0, rd_addr=0, slot_data=0, slot_cnt=0, overflow=0.
REQ-029 After rst_n release, first start SHALL behave per REQ-017 with no residue of the aborted scan.

Verification (N_SPR=32, K_SLOTS=4, ATTR_W=18 unless noted)
REQ-030 All attributes 0, start -> done at cycle 34, slot_cnt=0, slot_data=0, overflow=0; rd_en high cycles 1..32.
REQ-031 idx31=0x00001, idx5=0x3FFFF, idx0=0x000AA, others 0 -> slot0={1,0x00001}, slot1={27,0x3FFFF}, slot2={32,0x000AA}, slot3=0, slot_cnt=3, overflow=0, done cycle 34.
REQ-032 idx20..15 all 0x00123 -> slots tags 12,13,14,15, slot_cnt=4, overflow=1, idx16 evaluated cycle 17, done cycle 18, rd_en low from cycle 18.
REQ-033 Exactly idx3..0 active -> tags 29..32, slot_cnt=4, overflow=0, full scan, done cycle 34.
REQ-034 start pulsed at cycles 5 and 34 during scan -> ignored, single done at 34; rst_n low at cycle 10 -> all outputs 0 same cycle; new start after release completes normally.
REQ-035 Instance N_SPR=8, K_SLOTS=2: idx7,6,1 active -> tags 1,2, slot_cnt=2, overflow=1, done at cycle 9 (idx1 read cycle 7, evaluated cycle 8).
